// File: rtl/fpu_pkg.sv
// Shared types and IEEE field helpers for the FPU issue front end.
// Helpers take field widths as arguments so one package serves every format up to 64 bits.
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } fpu_state_e;

    // Bit positions inside the sticky vector {invalid,div_zero,overflow,underflow,inexact}
    localparam int STK_INX = 0;
    localparam int STK_UNF = 1;
    localparam int STK_OVF = 2;
    localparam int STK_DZ  = 3;
    localparam int STK_INV = 4;
    localparam int STK_W   = 5;

    localparam int FP_MAX_W = 64;
    typedef logic [FP_MAX_W-1:0] fp_max_t;

    // Sign bit is ignored; any nonzero exponent or mantissa bit (subnormals included) is nonzero
    function automatic logic is_zero(input fp_max_t x, input int exp_w, input int man_w);
        logic z;
        z = 1'b1;
        for (int i = 0; i < FP_MAX_W; i++) begin
            if (i < exp_w + man_w && x[i]) begin
                z = 1'b0;
            end
        end
        return z;
    endfunction

    function automatic fp_max_t make_inf(input logic sign, input int exp_w, input int man_w);
        fp_max_t r;
        r = '0;
        for (int i = 0; i < FP_MAX_W; i++) begin
            if (i >= man_w && i < man_w + exp_w) begin
                r[i] = 1'b1;
            end
            if (i == man_w + exp_w) begin
                r[i] = sign;
            end
        end
        return r;
    endfunction

    function automatic fp_max_t make_qnan(input int exp_w, input int man_w);
        fp_max_t r;
        r = '0;
        for (int i = 0; i < FP_MAX_W; i++) begin
            if ((i >= man_w && i < man_w + exp_w) || i == man_w - 1) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fpu_special_case.sv
// Combinational divide special-case detector: x/0 gives signed infinity, 0/0 gives the
// canonical quiet NaN; both results bypass the arithmetic core entirely.
module fpu_special_case
    import fpu_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0] i_op_a,
    input  logic [W-1:0] i_op_b,
    input  fpu_op_e      i_op,
    output logic         o_bypass,
    output logic [W-1:0] o_result,
    output logic         o_div_zero,
    output logic         o_invalid
);

    typedef logic [W-1:0] word_t;

    logic  w_a_zero;
    logic  w_b_zero;
    word_t w_inf;
    word_t w_qnan;

    assign w_a_zero = is_zero(fp_max_t'(i_op_a), EXP_W, MAN_W);
    assign w_b_zero = is_zero(fp_max_t'(i_op_b), EXP_W, MAN_W);
    assign w_inf    = word_t'(make_inf(i_op_a[W-1] ^ i_op_b[W-1], EXP_W, MAN_W));
    assign w_qnan   = word_t'(make_qnan(EXP_W, MAN_W));

    assign o_bypass   = (i_op == OP_DIV) && w_b_zero;
    assign o_div_zero = o_bypass && !w_a_zero;
    assign o_invalid  = o_bypass && w_a_zero;
    assign o_result   = w_a_zero ? w_qnan : w_inf;

endmodule

// File: rtl/fpu_issue_unit.sv
// Issue/sequencing front end: accepts one op per start/busy handshake, dispatches it to a
// fixed-latency core (or short-circuits divide special cases) and holds the result until taken.
module fpu_issue_unit
    import fpu_pkg::*;
#(
    parameter int EXP_W   = 5,
    parameter int MAN_W   = 10,
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] opA,
    input  logic [W-1:0] opB,
    output logic         busy,
    output logic [W-1:0] result,
    output logic         valid,
    input  logic         res_ready,
    output logic         overflow,
    output logic         underflow,
    output logic         inexact,
    output logic         div_zero,
    output logic         invalid,
    output logic [4:0]   sticky,
    input  logic         clear_sticky,
    output logic         core_go,
    output logic [1:0]   core_op,
    output logic [W-1:0] core_a,
    output logic [W-1:0] core_b,
    input  logic [W-1:0] core_res,
    input  logic         core_ovf,
    input  logic         core_unf,
    input  logic         core_inx
);

    localparam int MAX_LAT = (ADD_LAT > MUL_LAT)
                           ? ((ADD_LAT > DIV_LAT) ? ADD_LAT : DIV_LAT)
                           : ((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT);
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef logic [W-1:0]     word_t;
    typedef logic [CNT_W-1:0] cnt_t;

    fpu_state_e         r_state;
    fpu_state_e         w_next_state;
    fpu_op_e            r_op;
    fpu_op_e            w_op_in;
    word_t              r_core_a;
    word_t              r_core_b;
    word_t              r_result;
    word_t              w_special_result;
    cnt_t               r_cnt;
    cnt_t               w_lat_m1;
    logic               r_ovf;
    logic               r_unf;
    logic               r_inx;
    logic               r_dz;
    logic               r_inv;
    logic [STK_W-1:0]   r_sticky;
    logic [STK_W-1:0]   w_flags;
    logic               w_bypass;
    logic               w_sc_dz;
    logic               w_sc_inv;
    logic               w_busy;
    logic               w_accept;
    logic               w_release;
    logic               w_cnt_zero;
    logic               w_core_done;

    assign w_op_in = fpu_op_e'(op);

    fpu_special_case #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_special_case (
        .i_op_a     (opA),
        .i_op_b     (opB),
        .i_op       (w_op_in),
        .o_bypass   (w_bypass),
        .o_result   (w_special_result),
        .o_div_zero (w_sc_dz),
        .o_invalid  (w_sc_inv)
    );

    always_comb begin
        w_lat_m1 = cnt_t'(ADD_LAT - 1);
        case (r_op)
            OP_MUL:  w_lat_m1 = cnt_t'(MUL_LAT - 1);
            OP_DIV:  w_lat_m1 = cnt_t'(DIV_LAT - 1);
            default: w_lat_m1 = cnt_t'(ADD_LAT - 1);
        endcase
    end

    assign w_cnt_zero  = (r_cnt == '0);
    assign w_core_done = (r_state == ST_WAIT) && w_cnt_zero;
    assign w_release   = (r_state == ST_HOLD) && res_ready;
    assign w_accept    = start && !w_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A result being taken frees the unit in the same cycle, so HOLD can re-accept directly
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_next_state = w_bypass ? ST_HOLD : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_cnt_zero) begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    w_busy = 1'b0;
                    if (start) begin
                        w_next_state = w_bypass ? ST_HOLD : ST_ISSUE;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_flags          = '0;
        w_flags[STK_INX] = r_inx;
        w_flags[STK_UNF] = r_unf;
        w_flags[STK_OVF] = r_ovf;
        w_flags[STK_DZ]  = r_dz;
        w_flags[STK_INV] = r_inv;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op     <= OP_ADD;
            r_core_a <= '0;
            r_core_b <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_inx    <= 1'b0;
            r_dz     <= 1'b0;
            r_inv    <= 1'b0;
            r_sticky <= '0;
        end else begin
            // SUB is executed by the core as ADD of the negated second operand
            if (w_accept) begin
                r_op     <= w_op_in;
                r_core_a <= opA;
                r_core_b <= (w_op_in == OP_SUB) ? {~opB[W-1], opB[W-2:0]} : opB;
            end

            if (r_state == ST_ISSUE) begin
                r_cnt <= w_lat_m1;
            end else if (r_state == ST_WAIT && !w_cnt_zero) begin
                r_cnt <= r_cnt - cnt_t'(1);
            end

            if (w_accept && w_bypass) begin
                r_result <= w_special_result;
                r_ovf    <= 1'b0;
                r_unf    <= 1'b0;
                r_inx    <= 1'b0;
                r_dz     <= w_sc_dz;
                r_inv    <= w_sc_inv;
            end else if (w_core_done) begin
                r_result <= core_res;
                r_ovf    <= core_ovf;
                r_unf    <= core_unf;
                r_inx    <= core_inx;
                r_dz     <= 1'b0;
                r_inv    <= 1'b0;
            end

            // Flags of a result completing alongside a clear survive the clear
            if (w_release) begin
                r_sticky <= (clear_sticky ? '0 : r_sticky) | w_flags;
            end else if (clear_sticky) begin
                r_sticky <= '0;
            end
        end
    end

    assign busy      = w_busy;
    assign valid     = (r_state == ST_HOLD);
    assign result    = r_result;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign inexact   = r_inx;
    assign div_zero  = r_dz;
    assign invalid   = r_inv;
    assign sticky    = r_sticky;
    assign core_go   = (r_state == ST_ISSUE);
    assign core_op   = r_op;
    assign core_a    = r_core_a;
    assign core_b    = r_core_b;

endmodule

// File: tb/tb_fpu_issue_unit.sv
// Scoreboard bench for fpu_issue_unit: a delay-line core model returns bench-chosen results,
// expected results/flags/latency are queued at acceptance and checked by an independent monitor.
module tb_fpu_issue_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] opA, opB;
    logic        busy;
    logic [15:0] result;
    logic        valid;
    logic        res_ready;
    logic        overflow, underflow, inexact, div_zero, invalid;
    logic [4:0]  sticky;
    logic        clear_sticky;
    logic        core_go;
    logic [1:0]  core_op;
    logic [15:0] core_a, core_b;
    logic [15:0] core_res;
    logic        core_ovf, core_unf, core_inx;

    fpu_issue_unit #(
        .EXP_W(5), .MAN_W(10), .ADD_LAT(2), .MUL_LAT(3), .DIV_LAT(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
        .busy(busy), .result(result), .valid(valid), .res_ready(res_ready),
        .overflow(overflow), .underflow(underflow), .inexact(inexact),
        .div_zero(div_zero), .invalid(invalid), .sticky(sticky),
        .clear_sticky(clear_sticky), .core_go(core_go), .core_op(core_op),
        .core_a(core_a), .core_b(core_b), .core_res(core_res),
        .core_ovf(core_ovf), .core_unf(core_unf), .core_inx(core_inx)
    );

    typedef struct { logic [15:0] res; logic [4:0] flg; int exp_cyc; } sb_t;
    typedef struct { logic [1:0] op; logic [15:0] a; logic [15:0] b; logic [15:0] res; logic [2:0] flg; } core_t;
    typedef struct { int due; logic [15:0] res; logic [2:0] flg; } pend_t;

    sb_t   sbq[$];
    core_t coreq[$];
    pend_t pend[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rand_mode = 0;
    bit rr_dir = 1;
    bit clr_dir = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat(input logic [1:0] o);
        case (o)
            2'd0, 2'd1: return 2;
            2'd2:       return 3;
            default:    return 8;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request until accepted; the reference model decides the expected outcome
    task automatic send(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] cres, input logic [2:0] cflg, output int acc);
        bit    ok;
        bit    a0, b0;
        sb_t   e;
        core_t c;
        ok  = 0;
        acc = -1;
        start = 1'b1; op = o; opA = a; opB = b;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (!busy) begin
                ok  = 1;
                acc = cyc;
                a0  = (a[14:0] == 15'd0);
                b0  = (b[14:0] == 15'd0);
                if (o == 2'd3 && b0) begin
                    e.res     = a0 ? 16'h7E00 : {a[15] ^ b[15], 5'h1F, 10'h000};
                    e.flg     = a0 ? 5'b10000 : 5'b01000;
                    e.exp_cyc = cyc + 1;
                end else begin
                    e.res     = cres;
                    e.flg     = {2'b00, cflg};
                    e.exp_cyc = cyc + lat(o) + 2;
                    c.op  = o;
                    c.a   = a;
                    c.b   = (o == 2'd1) ? (b ^ 16'h8000) : b;
                    c.res = cres;
                    c.flg = cflg;
                    coreq.push_back(c);
                end
                sbq.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        chk("accept", 32'(ok), 32'd1);
        start = 1'b0;
        op  = 2'($urandom);
        opA = 16'($urandom);
        opB = 16'($urandom);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400 && sbq.size() != 0; t++) tick();
        chk("drain", sbq.size(), 0);
        tick();
    endtask

    // Consumer side: res_ready / clear_sticky, applied a little after the edge
    initial begin
        res_ready = 1'b0;
        clear_sticky = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rand_mode) begin
                res_ready    = ($urandom_range(0, 3) != 0);
                clear_sticky = ($urandom_range(0, 7) == 0);
            end else begin
                res_ready    = rr_dir;
                clear_sticky = clr_dir;
            end
        end
    end

    // Core model: LAT-deep delay line; outside the due cycle it drives garbage
    initial begin
        core_t c;
        pend_t p;
        core_res = '0;
        {core_ovf, core_unf, core_inx} = 3'b000;
        forever begin
            @(posedge clk);
            #1;
            while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
            if (pend.size() > 0 && pend[0].due == cyc) begin
                p = pend.pop_front();
                core_res = p.res;
                {core_ovf, core_unf, core_inx} = p.flg;
            end else begin
                core_res = 16'($urandom);
                {core_ovf, core_unf, core_inx} = 3'($urandom_range(0, 7));
            end
            @(negedge clk);
            if (reset && core_go) begin
                if (coreq.size() == 0) begin
                    chk("core_go_unexpected", 32'd1, 32'd0);
                end else begin
                    c = coreq.pop_front();
                    chk("core_op", core_op, c.op);
                    chk("core_a", core_a, c.a);
                    chk("core_b", core_b, c.b);
                    p.due = cyc + lat(c.op);
                    p.res = c.res;
                    p.flg = c.flg;
                    pend.push_back(p);
                end
            end
        end
    end

    // Monitor: latency, held result/flags, and sticky accumulation
    initial begin
        bit       fresh;
        logic [4:0] msticky;
        sb_t      e;
        fresh   = 1;
        msticky = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sbq.delete();
                fresh   = 1;
                msticky = '0;
            end else begin
                chk("sticky", sticky, msticky);
                if (valid) begin
                    if (sbq.size() == 0) begin
                        if (fresh) chk("valid_unexpected", 32'd1, 32'd0);
                    end else begin
                        if (fresh) chk("latency", cyc, sbq[0].exp_cyc);
                        chk("result", result, sbq[0].res);
                        chk("flags", {invalid, div_zero, overflow, underflow, inexact}, sbq[0].flg);
                    end
                    fresh = 0;
                end
                if (valid && res_ready && sbq.size() > 0) begin
                    e = sbq.pop_front();
                    msticky = (clear_sticky ? 5'b0 : msticky) | e.flg;
                    fresh = 1;
                end else begin
                    if (valid && res_ready) fresh = 1;
                    if (clear_sticky) msticky = '0;
                end
            end
        end
    end

    initial begin
        int acc;
        logic [1:0]  ro;
        logic [15:0] ra, rb;
        reset = 1'b0; start = 1'b0; op = '0; opA = '0; opB = '0;
        repeat (3) tick();
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_core_go", core_go, 0);
        chk("rst_core_ab", {core_a, core_b}, 0);
        chk("rst_core_op", core_op, 0);
        chk("rst_flags", {invalid, div_zero, overflow, underflow, inexact}, 0);
        reset = 1'b1;
        repeat (2) tick();

        // Basic core path: ADD, SUB (negated operand B), then divide special cases
        send(2'd0, 16'h3C00, 16'h4000, 16'h4200, 3'b000, acc);
        wait_drain();
        send(2'd1, 16'h4200, 16'h3C00, 16'h4000, 3'b000, acc);
        wait_drain();
        send(2'd3, 16'h3C00, 16'h8000, 16'h1111, 3'b000, acc);
        wait_drain();
        chk("sticky_div_zero", sticky, 5'b01000);
        send(2'd3, 16'h0000, 16'h0000, 16'h2222, 3'b000, acc);
        wait_drain();
        chk("sticky_invalid", sticky, 5'b11000);
        clr_dir = 1; tick(); clr_dir = 0; tick();
        chk("sticky_cleared", sticky, 5'b00000);

        // Stalled consumer: result held, busy high, extra starts ignored
        rr_dir = 0;
        send(2'd2, 16'h4000, 16'h4200, 16'h4600, 3'b001, acc);
        for (int t = 0; t < 20 && !valid; t++) tick();
        chk("mul_valid", valid, 1);
        for (int k = 0; k < 5; k++) begin
            start = 1'b1; op = 2'd0; opA = 16'($urandom); opB = 16'($urandom);
            @(negedge clk);
            chk("busy_stall", busy, 1);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rr_dir = 1;
        send(2'd2, 16'h3800, 16'h4400, 16'h4000, 3'b001, acc);
        wait_drain();
        chk("sticky_inx", sticky, 5'b00001);

        // Clear coinciding with a completion keeps that completion's flags
        send(2'd0, 16'h7800, 16'h7800, 16'h7C00, 3'b100, acc);
        while (cyc < acc + 4) tick();
        clr_dir = 1; tick(); clr_dir = 0;
        chk("sticky_clear_same", sticky, 5'b00100);
        clr_dir = 1; tick(); clr_dir = 0;
        chk("sticky_clear_only", sticky, 5'b00000);
        tick();

        // Reset in the middle of a divide's wait phase
        send(2'd3, 16'h4000, 16'h3C00, 16'h3800, 3'b010, acc);
        while (cyc < acc + 5) tick();
        reset = 1'b0;
        #1;
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_core", {core_go, core_op, core_a, core_b}, 0);
        chk("abort_sticky", sticky, 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (12) tick();
        send(2'd0, 16'h3C00, 16'h3C00, 16'h4000, 3'b000, acc);
        wait_drain();

        // Randomized traffic with random consumer back-pressure and clears
        rand_mode = 1;
        for (int n = 0; n < 150; n++) begin
            ro = 2'($urandom);
            ra = ($urandom_range(0, 5) == 0) ? {1'($urandom), 15'd0} : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? {1'($urandom), 15'd0} : 16'($urandom);
            send(ro, ra, rb, 16'($urandom), 3'($urandom_range(0, 7)), acc);
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_mode = 0;
        rr_dir = 1;
        clr_dir = 0;
        repeat (2) tick();
        wait_drain();
        chk("coreq_empty", coreq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
